wptr_full_prog: RTL and testbench

WPTR_FULL_PROG -- requirements
Module: wptr_full_prog

---
 rtl/fifo_ptr_pkg.sv | 32 +++
 rtl/wptr_full_prog_if.sv | 29 ++
 rtl/sync_ff.sv | 31 +++
 rtl/wptr_full_prog.sv | 106 ++++++++++
 tb/tb_wptr_full_prog.sv | 191 +++++++++++++++++++
 5 files changed

// File: rtl/fifo_ptr_pkg.sv
// Shared pointer helpers for the async FIFO write/read pointer blocks.
// Holds Gray<->binary conversion functions and the legal synchronizer depth range.
// Functions work on a fixed maximum width; callers size-cast in and out.
package fifo_ptr_pkg;

    localparam int SYNC_STAGES_MIN = 2;
    localparam int SYNC_STAGES_MAX = 4;
    localparam int PTR_MAXW        = 32;

    // Zero-extension is harmless for both conversions: leading zeros stay zero
    // in Gray and contribute nothing to the prefix-XOR of gray2bin.
    function automatic logic [PTR_MAXW-1:0] bin2gray(input logic [PTR_MAXW-1:0] bin);
        return bin ^ (bin >> 1);
    endfunction

    function automatic logic [PTR_MAXW-1:0] gray2bin(input logic [PTR_MAXW-1:0] gray);
        logic [PTR_MAXW-1:0] bin;
        bin[PTR_MAXW-1] = gray[PTR_MAXW-1];
        for (int i = PTR_MAXW - 2; i >= 0; i--) begin
            bin[i] = bin[i+1] ^ gray[i];
        end
        return bin;
    endfunction

    // Out-of-range synchronizer depths are pulled back into the legal range.
    function automatic int clamp_sync_stages(input int n);
        if (n < SYNC_STAGES_MIN) return SYNC_STAGES_MIN;
        if (n > SYNC_STAGES_MAX) return SYNC_STAGES_MAX;
        return n;
    endfunction

endpackage

// File: rtl/wptr_full_prog_if.sv
// Write-side pointer/flag bundle of the async FIFO.
// master: write-domain client (drives winc, rptr_gray, afull_thresh, ovf_clr).
// slave: wptr_full_prog (drives wfull, wafull, waddr, wptr, wlevel, ovf, drop_cnt).
interface wptr_full_prog_if #(
    parameter int ADDRSIZE = 4,
    parameter int DROPW    = 16
);
    logic                winc;
    logic [ADDRSIZE:0]   rptr_gray;
    logic [ADDRSIZE:0]   afull_thresh;
    logic                ovf_clr;
    logic                wfull;
    logic                wafull;
    logic [ADDRSIZE-1:0] waddr;
    logic [ADDRSIZE:0]   wptr;
    logic [ADDRSIZE:0]   wlevel;
    logic                ovf;
    logic [DROPW-1:0]    drop_cnt;

    modport master (
        output winc, rptr_gray, afull_thresh, ovf_clr,
        input  wfull, wafull, waddr, wptr, wlevel, ovf, drop_cnt
    );

    modport slave (
        input  winc, rptr_gray, afull_thresh, ovf_clr,
        output wfull, wafull, waddr, wptr, wlevel, ovf, drop_cnt
    );
endinterface

// File: rtl/sync_ff.sv
// Multi-flop synchronizer for a Gray-coded bus crossing into clk_i.
// Ports: clk_i, rst_i (async active-high), d_i (foreign-domain bus), q_o (synchronized).
// Latency: STAGES clk_i edges from d_i to q_o.
module sync_ff #(
    parameter int STAGES = 2,
    parameter int WIDTH  = 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] sync_q [STAGES];

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < STAGES; i++) begin
                sync_q[i] <= '0;
            end
        end else begin
            sync_q[0] <= d_i;
            for (int i = 1; i < STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
        end
    end

    assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/wptr_full_prog.sv
// Async FIFO write-pointer / full-flag block with programmable almost-full and overflow tracking.
// Ports: wclk, wrst (async active-high); wif (slave) carries winc, rptr_gray, afull_thresh,
//   ovf_clr in and wfull, wafull, waddr, wptr, wlevel, ovf, drop_cnt out.
// Latency: writes show in flags/level 1 edge later; read advances SYNC_STAGES+1 edges later.
// Backpressure: winc while wfull is dropped, counted in drop_cnt (saturating), and sets sticky ovf.
module wptr_full_prog
    import fifo_ptr_pkg::*;
#(
    parameter int ADDRSIZE    = 4,
    parameter int SYNC_STAGES = 2,
    parameter int DROPW       = 16
) (
    input  logic          wclk,
    input  logic          wrst,
    wptr_full_prog_if.slave wif
);

    localparam int              PW        = ADDRSIZE + 1;
    localparam int              SYNC_N    = clamp_sync_stages(SYNC_STAGES);
    localparam logic [PW-1:0]   DEPTH_LVL = {1'b1, {ADDRSIZE{1'b0}}};
    localparam logic [DROPW-1:0] DROP_MAX = '1;

    logic [PW-1:0]    wq_rptr;
    logic [PW-1:0]    rbin_s;

    logic [PW-1:0]    wbin_q,     wbin_d;
    logic [PW-1:0]    wptr_q,     wptr_d;
    logic [PW-1:0]    wlevel_q,   wlevel_d;
    logic             wfull_q,    wfull_d;
    logic             wafull_q,   wafull_d;
    logic             ovf_q,      ovf_d;
    logic [DROPW-1:0] drop_cnt_q, drop_cnt_d;

    logic             wr_ok;
    logic             wr_rej;

    sync_ff #(
        .STAGES (SYNC_N),
        .WIDTH  (PW)
    ) u_rptr_sync (
        .clk_i  (wclk),
        .rst_i  (wrst),
        .d_i    (wif.rptr_gray),
        .q_o    (wq_rptr)
    );

    always_comb begin
        rbin_s     = PW'(gray2bin(PTR_MAXW'(wq_rptr)));
        wr_ok      = wif.winc & ~wfull_q;
        wr_rej     = wif.winc & wfull_q;

        wbin_d     = wbin_q + PW'(wr_ok);
        wptr_d     = PW'(bin2gray(PTR_MAXW'(wbin_d)));
        // Modulo subtraction keeps the level correct across the pointer wrap.
        wlevel_d   = wbin_d - rbin_s;
        // Level == DEPTH is the same condition as the classic Gray test
        // (top two bits inverted, remaining bits equal), but reads more plainly.
        wfull_d    = (wlevel_d == DEPTH_LVL);
        wafull_d   = (wlevel_d >= wif.afull_thresh);

        ovf_d      = ovf_q;
        drop_cnt_d = drop_cnt_q;
        // A rejected write in the same cycle as ovf_clr wins: it is the first
        // drop of the fresh counting window.
        if (wr_rej) begin
            ovf_d = 1'b1;
            if (wif.ovf_clr) begin
                drop_cnt_d = DROPW'(1);
            end else if (drop_cnt_q != DROP_MAX) begin
                drop_cnt_d = drop_cnt_q + DROPW'(1);
            end
        end else if (wif.ovf_clr) begin
            ovf_d      = 1'b0;
            drop_cnt_d = '0;
        end
    end

    always_ff @(posedge wclk or posedge wrst) begin
        if (wrst) begin
            wbin_q     <= '0;
            wptr_q     <= '0;
            wlevel_q   <= '0;
            wfull_q    <= 1'b0;
            wafull_q   <= 1'b0;
            ovf_q      <= 1'b0;
            drop_cnt_q <= '0;
        end else begin
            wbin_q     <= wbin_d;
            wptr_q     <= wptr_d;
            wlevel_q   <= wlevel_d;
            wfull_q    <= wfull_d;
            wafull_q   <= wafull_d;
            ovf_q      <= ovf_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    assign wif.waddr    = wbin_q[ADDRSIZE-1:0];
    assign wif.wptr     = wptr_q;
    assign wif.wlevel   = wlevel_q;
    assign wif.wfull    = wfull_q;
    assign wif.wafull   = wafull_q;
    assign wif.ovf      = ovf_q;
    assign wif.drop_cnt = drop_cnt_q;

endmodule

// File: tb/tb_wptr_full_prog.sv
// Directed bench for wptr_full_prog (ADDRSIZE=4, SYNC_STAGES=2, DROPW=16).
// Inputs change 1 time unit after the rising edge; outputs are sampled at the same point.
// Expected values are hand-derived constants or the small gray5() helper.
module tb_wptr_full_prog;

    localparam int AW = 4;

    logic wclk = 1'b0;
    logic wrst;

    always #5 wclk = ~wclk;

    wptr_full_prog_if #(.ADDRSIZE(AW), .DROPW(16)) wif ();

    wptr_full_prog #(
        .ADDRSIZE    (AW),
        .SYNC_STAGES (2),
        .DROPW       (16)
    ) dut (
        .wclk (wclk),
        .wrst (wrst),
        .wif  (wif.slave)
    );

    int n_chk = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge wclk);
        #1;
    endtask

    function automatic logic [4:0] gray5(input int v);
        logic [4:0] b;
        b = 5'(v);
        return b ^ (b >> 1);
    endfunction

    task automatic check_all_zero(input string tag);
        check({tag, "_wfull"},  32'(wif.wfull),    32'd0);
        check({tag, "_wafull"}, 32'(wif.wafull),   32'd0);
        check({tag, "_wlevel"}, 32'(wif.wlevel),   32'd0);
        check({tag, "_wptr"},   32'(wif.wptr),     32'd0);
        check({tag, "_waddr"},  32'(wif.waddr),    32'd0);
        check({tag, "_ovf"},    32'(wif.ovf),      32'd0);
        check({tag, "_drop"},   32'(wif.drop_cnt), 32'd0);
    endtask

    initial begin
        logic [4:0] prev_wptr;

        // Reset with winc held high: must be ignored.
        wrst             = 1'b1;
        wif.winc         = 1'b1;
        wif.rptr_gray    = '0;
        wif.afull_thresh = 5'd12;
        wif.ovf_clr      = 1'b0;
        tick();
        tick();
        tick();
        check_all_zero("rst");
        wrst     = 1'b0;
        wif.winc = 1'b0;
        tick();
        check_all_zero("idle");

        // Fill 16 entries with read pointer at 0; almost-full threshold 12.
        for (int i = 0; i < 16; i++) begin
            wif.winc = 1'b1;
            check($sformatf("fill_waddr%0d", i), 32'(wif.waddr), 32'(i));
            tick();
            check($sformatf("fill_lvl%0d", i),   32'(wif.wlevel), 32'(i + 1));
            check($sformatf("fill_full%0d", i),  32'(wif.wfull),  32'(i == 15));
            check($sformatf("fill_afull%0d", i), 32'(wif.wafull), 32'(i + 1 >= 12));
            check($sformatf("fill_wptr%0d", i),  32'(wif.wptr),   32'(gray5(i + 1)));
        end

        // Three writes against a full FIFO are dropped.
        for (int k = 1; k <= 3; k++) begin
            wif.winc = 1'b1;
            tick();
            check($sformatf("ovf_wptr%0d", k), 32'(wif.wptr),     32'd24);
            check($sformatf("ovf_flag%0d", k), 32'(wif.ovf),      32'd1);
            check($sformatf("ovf_drop%0d", k), 32'(wif.drop_cnt), 32'(k));
        end
        wif.ovf_clr = 1'b1;
        tick();
        check("clr_rej_drop", 32'(wif.drop_cnt), 32'd1);
        check("clr_rej_ovf",  32'(wif.ovf),      32'd1);
        wif.winc = 1'b0;
        tick();
        check("clr_drop", 32'(wif.drop_cnt), 32'd0);
        check("clr_ovf",  32'(wif.ovf),      32'd0);
        wif.ovf_clr = 1'b0;

        // One read: visible exactly three edges later.
        wif.rptr_gray = gray5(1);
        tick();
        check("rd_e1_full", 32'(wif.wfull),  32'd1);
        check("rd_e1_lvl",  32'(wif.wlevel), 32'd16);
        tick();
        check("rd_e2_full", 32'(wif.wfull),  32'd1);
        check("rd_e2_lvl",  32'(wif.wlevel), 32'd16);
        tick();
        check("rd_e3_full",  32'(wif.wfull),  32'd0);
        check("rd_e3_lvl",   32'(wif.wlevel), 32'd15);
        check("rd_e3_afull", 32'(wif.wafull), 32'd1);

        // Drain to level 9.
        for (int r = 2; r <= 7; r++) begin
            wif.rptr_gray = gray5(r);
            tick();
        end
        tick();
        tick();
        tick();
        check("drain_lvl",   32'(wif.wlevel), 32'd9);
        check("drain_afull", 32'(wif.wafull), 32'd0);

        // Mid-fill reset clears outputs asynchronously.
        wrst          = 1'b1;
        wif.rptr_gray = '0;
        #1;
        check_all_zero("midrst");
        @(posedge wclk);
        #1;
        wrst     = 1'b0;
        wif.winc = 1'b1;
        check("resume_waddr0", 32'(wif.waddr), 32'd0);
        tick();
        wif.winc = 1'b0;
        check("resume_lvl",    32'(wif.wlevel), 32'd1);
        check("resume_waddr1", 32'(wif.waddr),  32'd1);
        check("resume_wptr",   32'(wif.wptr),   32'd1);

        // Continuous write+read across the pointer wrap.
        prev_wptr = gray5(1);
        for (int k = 1; k <= 40; k++) begin
            wif.winc      = 1'b1;
            wif.rptr_gray = gray5(k % 32);
            tick();
            check($sformatf("wrap_wptr%0d", k), 32'(wif.wptr),  32'(gray5((1 + k) % 32)));
            check($sformatf("wrap_step%0d", k), 32'($countones(wif.wptr ^ prev_wptr)), 32'd1);
            check($sformatf("wrap_lvl%0d", k),  32'(wif.wlevel), (k < 3) ? 32'(k + 1) : 32'd3);
            check($sformatf("wrap_full%0d", k), 32'(wif.wfull), 32'd0);
            prev_wptr = wif.wptr;
        end
        wif.winc = 1'b0;
        tick();
        tick();
        tick();
        check("wrap_settle_lvl", 32'(wif.wlevel), 32'd1);

        // Threshold 0: almost-full from the first edge after reset.
        wif.afull_thresh = 5'd0;
        wrst             = 1'b1;
        wif.rptr_gray    = '0;
        #1;
        check("th0_rst_afull", 32'(wif.wafull), 32'd0);
        @(posedge wclk);
        #1;
        wrst = 1'b0;
        tick();
        check("th0_afull", 32'(wif.wafull), 32'd1);
        check("th0_lvl",   32'(wif.wlevel), 32'd0);

        // Threshold above depth: never almost-full, even when full.
        wif.afull_thresh = 5'd17;
        for (int i = 0; i < 16; i++) begin
            wif.winc = 1'b1;
            tick();
        end
        wif.winc = 1'b0;
        tick();
        check("th17_full",  32'(wif.wfull),  32'd1);
        check("th17_afull", 32'(wif.wafull), 32'd0);
        check("th17_lvl",   32'(wif.wlevel), 32'd16);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
